counter32_timer: RTL
====================

# counter32_timer

Programmable 32-bit down-counting timer cell for the wsn-soc reconfigurable fabric cell library. It sits directly downstream of the flip-flop mapping pass: every state element in it is a plain positive-edge flop with synchronous reset, so the cell maps onto the fabric's synchronous DFFs without any asynchronous-reset conversion. The application FSMs use it to time sensor sampling and measurement intervals, with one-shot or auto-reload operation and terminal-count and compare pulses.

## Interface
Parameters:
- WIDTH, 32, counter width in bits (legal range 2..32)

Ports:
- CLK  in  1  clock; all state changes on the rising edge
- RST  in  1  reset; synchronous, active-high
- Start_i  in  1  load Reload_i and run; level sampled each edge
- Stop_i  in  1  halt counting; level sampled each edge
- AutoReload_i  in  1  1 = reload at terminal count, 0 = one-shot
- Reload_i  in  WIDTH  start/reload value
- Compare_i  in  WIDTH  match value (only with CMP feature)
- Count_o  out  WIDTH  current count, registered
- Running_o  out  1  high while in RUN
- Expired_o  out  1  one-cycle pulse at terminal count
- Match_o  out  1  one-cycle pulse on compare hit (only with CMP feature)

## Operation
- States: IDLE, RUN, DONE.
- Reset values: IDLE, Count_o=0, Running_o=0, Expired_o=0, Match_o=0.
- IDLE or DONE, Start_i=1, Stop_i=0:
  - Reload_i != 0: Count_o <= Reload_i, go to RUN.
  - Reload_i == 0: Count_o <= 0, Expired_o <= 1, go to DONE. No auto-reload, to avoid a pulse every cycle.
- RUN, no Start/Stop:
  - Count_o > 1: Count_o <= Count_o-1.
  - Count_o == 1: Count_o <= 0 and Expired_o <= 1. Then, if AutoReload_i=1, stay in RUN; otherwise go to DONE.
  - Count_o == 0 (only after auto-reload expiry): Count_o <= Reload_i and stay in RUN. If Reload_i=0 at that point, go to DONE.
- RUN, Start_i=1, Stop_i=0: restart with Count_o <= Reload_i, following the same Reload_i==0 rule as above.
- Stop_i=1 in any state: go to IDLE, hold Count_o, no pulses. Stop_i wins over a simultaneous Start_i.
- DONE: holds Count_o=0. Leaves DONE only on Start_i or Stop_i.
- Arithmetic: Count_o never wraps. Decrement happens only when Count_o >= 1.
- AutoReload_i is sampled at the terminal-count edge only.
- Expired_o and Match_o are deasserted on every edge where their condition is false. They never stretch beyond one cycle.
- RST=1 overrides all inputs on the same edge.

## Timing
- Start_i sampled at edge k: Count_o=Reload_i and Running_o=1 after edge k.
- One-shot with Reload_i=N (N >= 1): Expired_o high during the cycle after edge k+N, with Count_o=0 and Running_o=0.
- Auto-reload period: N+1 cycles between Expired_o pulses.
- Count_o, Running_o and pulse outputs are all registered. There is no combinational input-to-output path.
- Running_o=1 exactly in the RUN state.

## Configuration
- Macro: COUNTER32_TIMER_CMP_EN.
- Defined:
  - Compare_i and Match_o exist.
  - Match_o <= 1 on a RUN-state decrement edge whose new Count_o equals Compare_i.
  - Loads and reloads never produce Match_o.
- Undefined:
  - Compare_i and Match_o are absent from the port list.
  - No comparator logic is generated.
  - All other behaviour is identical.

## Structure
- Package counter32_timer_pkg holds:
  - the state enum (IDLE, RUN, DONE, 2-bit encoding 00/01/10)
  - the default-width constant
- Sub-module counter32_core: WIDTH-bit register with synchronous reset, load (load has priority), decrement-enable and a zero flag. The FSM and pulse logic stay in counter32_timer.

## Test plan
- Reset: RST=1 for 2 cycles with Start_i=1 -> Count_o=0, Running_o=0, no pulses.
- One-shot: Reload_i=5, Start_i for 1 cycle -> Count_o 5,4,3,2,1,0; Expired_o high one cycle with Count_o=0; DONE holds 0.
- Auto-reload: Reload_i=3, AutoReload_i=1 -> Expired_o pulses every 4 cycles; Count_o sequence 3,2,1,0,3,...
- Stop/restart: Reload_i=10, Stop_i at Count_o=6 -> Count_o holds 6, Running_o=0; Start_i+Stop_i together -> stays IDLE; Start_i alone -> Count_o=10.
- Zero load: Reload_i=0, Start_i -> Expired_o one cycle after the edge, state DONE, Running_o never high.
- CMP (macro defined): Reload_i=8, Compare_i=3 -> Match_o single pulse when Count_o reaches 3. With Compare_i=8, no pulse from the load.

Source files
------------

// File: rtl/counter32_timer_pkg.sv
// Shared types and constants for the counter32_timer cell.
package counter32_timer_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/counter32_core.sv
// counter32_core: loadable down-counter register with a zero flag.
// Load has priority over decrement; decrement saturates at zero.
module counter32_core
  import counter32_timer_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_dec,
  output logic [WIDTH-1:0] o_count,
  output logic             o_zero_c
);

  logic [WIDTH-1:0] r_count;

  // Count register: reset, load, or non-wrapping decrement
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign o_count  = r_count;
  assign o_zero_c = (r_count == '0);

endmodule

// File: rtl/counter32_timer.sv
// counter32_timer: programmable down-counting timer, one-shot or auto-reload.
// Optional compare output enabled by defining COUNTER32_TIMER_CMP_EN.
module counter32_timer
  import counter32_timer_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start_i,
  input  logic             Stop_i,
  input  logic             AutoReload_i,
  input  logic [WIDTH-1:0] Reload_i,
`ifdef COUNTER32_TIMER_CMP_EN
  input  logic [WIDTH-1:0] Compare_i,
  output logic             Match_o,
`endif
  output logic [WIDTH-1:0] Count_o,
  output logic             Running_o,
  output logic             Expired_o
);

  state_t r_state;
  state_t w_state_nxt;
  logic   w_load;
  logic   w_dec;
  logic   w_zero;
  logic   w_is_one;
  logic   w_expired_nxt;
  logic   r_running;
  logic   r_expired;

  counter32_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .i_clk     (CLK),
    .i_rst     (RST),
    .i_load    (w_load),
    .i_load_val(Reload_i),
    .i_dec     (w_dec),
    .o_count   (Count_o),
    .o_zero_c  (w_zero)
  );

  assign w_is_one = (Count_o == WIDTH'(1));

  // Next-state, counter control and pulse decode; Stop beats Start
  always_comb begin
    w_state_nxt   = r_state;
    w_load        = 1'b0;
    w_dec         = 1'b0;
    w_expired_nxt = 1'b0;
    if (Stop_i) begin
      w_state_nxt = IDLE;
    end else if (Start_i) begin
      // Zero load expires at once and parks in DONE to avoid a pulse storm
      w_load = 1'b1;
      if (Reload_i == '0) begin
        w_state_nxt   = DONE;
        w_expired_nxt = 1'b1;
      end else begin
        w_state_nxt = RUN;
      end
    end else begin
      case (r_state)
        RUN: begin
          if (w_zero) begin
            // Count of zero in RUN only follows an auto-reload expiry
            w_load = 1'b1;
            if (Reload_i == '0) begin
              w_state_nxt = DONE;
            end
          end else begin
            w_dec = 1'b1;
            if (w_is_one) begin
              w_expired_nxt = 1'b1;
              if (!AutoReload_i) begin
                w_state_nxt = DONE;
              end
            end
          end
        end
        default: begin
          w_state_nxt = r_state;
        end
      endcase
    end
  end

  // State and registered status outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= IDLE;
      r_running <= 1'b0;
      r_expired <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_running <= (w_state_nxt == RUN);
      r_expired <= w_expired_nxt;
    end
  end

  assign Running_o = r_running;
  assign Expired_o = r_expired;

`ifdef COUNTER32_TIMER_CMP_EN
  logic w_match_nxt;
  logic r_match;

  // Match only on a decrement landing on Compare_i, never on loads
  always_comb begin
    w_match_nxt = w_dec && ((Count_o - WIDTH'(1)) == Compare_i);
  end

  // Registered one-cycle match pulse
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_match <= 1'b0;
    end else begin
      r_match <= w_match_nxt;
    end
  end

  assign Match_o = r_match;
`endif

endmodule
